// File: rtl/pixel_receive_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_receive_interface_pkg
// Description : Shared defaults and write-FSM state encoding for the pixel
//               receive interface.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_receive_interface_pkg;

    // Default frame geometry and datapath widths
    localparam int C_COL_LEN_DEFAULT    = 640;
    localparam int C_ROW_LEN_DEFAULT    = 480;
    localparam int C_PIXEL_W_DEFAULT    = 12;
    localparam int C_ADDR_W_DEFAULT     = 19;
    localparam int C_FIFO_DEPTH_DEFAULT = 4;

    // Coordinate inputs are fixed at 10 bits
    localparam int C_COORD_W = 10;

    // Write FSM states
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } wr_state_e;

endpackage : pixel_receive_interface_pkg
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_fifo
// Description : Synchronous first-word-fall-through FIFO. dout always shows
//               the head entry while empty is low. The caller must not push
//               when full (unless popping in the same cycle) nor pop when
//               empty.
// Ports       : Clock, Reset (sync, active-high), push, pop, din -> dout,
//               full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [PTR_W:0]   r_cnt_q,  w_cnt_d;

    // DEPTH is a power of two, so pointers wrap naturally
    always_comb begin
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        w_cnt_d  = r_cnt_q;
        if (push) begin
            w_wptr_d = r_wptr_q + PTR_W'(1);
        end
        if (pop) begin
            w_rptr_d = r_rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   w_cnt_d = r_cnt_q + (PTR_W+1)'(1);
            2'b01:   w_cnt_d = r_cnt_q - (PTR_W+1)'(1);
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone defines validity
    always_ff @(posedge Clock) begin
        if (push) begin
            r_mem_q[r_wptr_q] <= din;
        end
    end

    assign dout  = r_mem_q[r_rptr_q];
    assign full  = (r_cnt_q == (PTR_W+1)'(DEPTH));
    assign empty = (r_cnt_q == '0);

endmodule : rx_fifo
`default_nettype wire

// File: rtl/pixel_receive_interface.sv
`default_nettype none
// ============================================================================
// Module      : pixel_receive_interface
// Description : Receiving end of the strobed pixel link. Range-checks and
//               linearises pixel coordinates (addr = row*COL_LEN + col),
//               buffers {addr, pixel} in rx_fifo and drains it to memory via
//               a mem_we/mem_ready handshake. Counts pixels per frame, pulses
//               frame_done on frame completion and flags sticky errors.
// Ports       : Clock, Reset (sync, active-high)
//               pixel, row_index, column_index, strobe  - pixel input
//               mem_addr, mem_data, mem_we, mem_ready   - memory write port
//               frame_done, overflow_err, range_err     - status
//               pixel_count, frame_checksum             - statistics
// Options     : RX_CHECKSUM_EN - when defined, frame_checksum holds the
//               modulo-2^16 sum of the last completed frame's pixels;
//               otherwise it is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_receive_interface
    import pixel_receive_interface_pkg::*;
#(
    parameter int COL_LEN    = C_COL_LEN_DEFAULT,
    parameter int ROW_LEN    = C_ROW_LEN_DEFAULT,
    parameter int PIXEL_W    = C_PIXEL_W_DEFAULT,
    parameter int ADDR_W     = C_ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH = C_FIFO_DEPTH_DEFAULT
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [PIXEL_W-1:0]   pixel,
    input  logic [C_COORD_W-1:0] row_index,
    input  logic [C_COORD_W-1:0] column_index,
    input  logic                 strobe,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [PIXEL_W-1:0]   mem_data,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic                 frame_done,
    output logic                 overflow_err,
    output logic                 range_err,
    output logic [ADDR_W-1:0]    pixel_count,
    output logic [15:0]          frame_checksum
);

    localparam int                C_ENTRY_W   = ADDR_W + PIXEL_W;
    localparam logic [ADDR_W-1:0] C_FRAME_PIX = ADDR_W'(COL_LEN * ROW_LEN);

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic                 w_in_range;
    logic [ADDR_W-1:0]    w_lin_addr;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [C_ENTRY_W-1:0] w_fifo_dout;

    assign w_in_range = (32'(row_index) < 32'(ROW_LEN)) &&
                        (32'(column_index) < 32'(COL_LEN));

    assign w_lin_addr = ADDR_W'(row_index) * ADDR_W'(COL_LEN) + ADDR_W'(column_index);

    // A full FIFO still accepts a pixel when the head leaves this cycle
    assign w_push = strobe && w_in_range && (!w_fifo_full || w_pop);

    rx_fifo #(
        .WIDTH (C_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({w_lin_addr, pixel}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    wr_state_e            r_state_q, w_state_d;
    logic [ADDR_W-1:0]    r_addr_q,  w_addr_d;
    logic [PIXEL_W-1:0]   r_data_q,  w_data_d;
    logic                 r_we_q,    w_we_d;
    logic                 w_wr_done;

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_data_d  = r_data_q;
        w_we_d    = r_we_q;
        w_pop     = 1'b0;
        w_wr_done = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                w_we_d = 1'b0;
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_addr_d  = w_fifo_dout[C_ENTRY_W-1:PIXEL_W];
                    w_data_d  = w_fifo_dout[PIXEL_W-1:0];
                    w_we_d    = 1'b1;
                    w_state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_we_q && mem_ready) begin
                    w_wr_done = 1'b1;
                    if (!w_fifo_empty) begin
                        // Back-to-back: next entry is presented immediately
                        w_pop    = 1'b1;
                        w_addr_d = w_fifo_dout[C_ENTRY_W-1:PIXEL_W];
                        w_data_d = w_fifo_dout[PIXEL_W-1:0];
                    end else begin
                        w_we_d    = 1'b0;
                        w_state_d = S_IDLE;
                    end
                end
            end
            default: begin
                w_we_d    = 1'b0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame counter and sticky errors
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_cnt_q, w_cnt_d;
    logic [ADDR_W-1:0] w_cnt_inc;
    logic              w_last;
    logic              r_frame_done_q, w_frame_done_d;
    logic              r_ovf_q, w_ovf_d;
    logic              r_rng_q, w_rng_d;

    always_comb begin
        w_cnt_inc      = r_cnt_q + ADDR_W'(1);
        w_last         = w_wr_done && (w_cnt_inc == C_FRAME_PIX);
        w_cnt_d        = r_cnt_q;
        if (w_wr_done) begin
            w_cnt_d = w_last ? '0 : w_cnt_inc;
        end
        w_frame_done_d = w_last;
        w_ovf_d        = r_ovf_q | (strobe && w_in_range && w_fifo_full && !w_pop);
        w_rng_d        = r_rng_q | (strobe && !w_in_range);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state_q      <= S_IDLE;
            r_addr_q       <= '0;
            r_data_q       <= '0;
            r_we_q         <= 1'b0;
            r_cnt_q        <= '0;
            r_frame_done_q <= 1'b0;
            r_ovf_q        <= 1'b0;
            r_rng_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_addr_q       <= w_addr_d;
            r_data_q       <= w_data_d;
            r_we_q         <= w_we_d;
            r_cnt_q        <= w_cnt_d;
            r_frame_done_q <= w_frame_done_d;
            r_ovf_q        <= w_ovf_d;
            r_rng_q        <= w_rng_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional frame checksum
    // ------------------------------------------------------------------
`ifdef RX_CHECKSUM_EN
    logic [15:0] r_acc_q,  w_acc_d;
    logic [15:0] r_csum_q, w_csum_d;
    logic [15:0] w_sum;

    // The pixel being written is the one held in the write register
    always_comb begin
        w_sum    = r_acc_q + 16'(r_data_q);
        w_acc_d  = r_acc_q;
        w_csum_d = r_csum_q;
        if (w_wr_done) begin
            if (w_last) begin
                w_csum_d = w_sum;
                w_acc_d  = '0;
            end else begin
                w_acc_d = w_sum;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_acc_q  <= '0;
            r_csum_q <= '0;
        end else begin
            r_acc_q  <= w_acc_d;
            r_csum_q <= w_csum_d;
        end
    end

    assign frame_checksum = r_csum_q;
`else
    assign frame_checksum = 16'd0;
`endif

    assign mem_addr     = r_addr_q;
    assign mem_data     = r_data_q;
    assign mem_we       = r_we_q;
    assign frame_done   = r_frame_done_q;
    assign overflow_err = r_ovf_q;
    assign range_err    = r_rng_q;
    assign pixel_count  = r_cnt_q;

endmodule : pixel_receive_interface
`default_nettype wire

// File: tb/tb_pixel_receive_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_receive_interface
// Description : Directed self-checking bench. Instance u_dut uses the default
//               640x480 geometry; u_small uses a 4x2 frame for frame
//               completion and checksum checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_receive_interface;

    logic Clock = 1'b0;
    logic Reset;

    // Default-geometry instance
    logic [11:0] pixel;
    logic [9:0]  row_index, column_index;
    logic        strobe, mem_ready;
    logic [18:0] mem_addr, pixel_count;
    logic [11:0] mem_data;
    logic        mem_we, frame_done, overflow_err, range_err;
    logic [15:0] frame_checksum;

    // Small-frame instance
    logic [11:0] b_pixel;
    logic [9:0]  b_row, b_col;
    logic        b_strobe, b_ready;
    logic [18:0] b_addr, b_count;
    logic [11:0] b_data;
    logic        b_we, b_done, b_ovf, b_rng;
    logic [15:0] b_csum;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_csum;

    always #5 Clock = ~Clock;

    pixel_receive_interface u_dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .pixel          (pixel),
        .row_index      (row_index),
        .column_index   (column_index),
        .strobe         (strobe),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .mem_ready      (mem_ready),
        .frame_done     (frame_done),
        .overflow_err   (overflow_err),
        .range_err      (range_err),
        .pixel_count    (pixel_count),
        .frame_checksum (frame_checksum)
    );

    pixel_receive_interface #(.COL_LEN(4), .ROW_LEN(2)) u_small (
        .Clock          (Clock),
        .Reset          (Reset),
        .pixel          (b_pixel),
        .row_index      (b_row),
        .column_index   (b_col),
        .strobe         (b_strobe),
        .mem_addr       (b_addr),
        .mem_data       (b_data),
        .mem_we         (b_we),
        .mem_ready      (b_ready),
        .frame_done     (b_done),
        .overflow_err   (b_ovf),
        .range_err      (b_rng),
        .pixel_count    (b_count),
        .frame_checksum (b_csum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
`ifdef RX_CHECKSUM_EN
        exp_csum = 16'h7FF8;
`else
        exp_csum = 16'h0000;
`endif
        Reset = 1'b1;
        pixel = '0; row_index = '0; column_index = '0; strobe = 1'b0; mem_ready = 1'b1;
        b_pixel = '0; b_row = '0; b_col = '0; b_strobe = 1'b0; b_ready = 1'b1;
        step();
        step();
        Reset = 1'b0;

        // Reset state
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_count", 32'(pixel_count), 32'd0);
        chk("rst_ovf",   32'(overflow_err), 32'd0);
        chk("rst_rng",   32'(range_err), 32'd0);
        chk("rst_done",  32'(frame_done), 32'd0);
        chk("rst_csum",  32'(frame_checksum), 32'd0);

        // Single pixel: row 2, col 5 -> 2*640+5 = 1285
        strobe = 1'b1; row_index = 10'd2; column_index = 10'd5; pixel = 12'hABC;
        step();
        strobe = 1'b0;
        chk("single_lat0_we", 32'(mem_we), 32'd0);
        step();
        chk("single_we",    32'(mem_we), 32'd1);
        chk("single_addr",  32'(mem_addr), 32'd1285);
        chk("single_data",  32'(mem_data), 32'hABC);
        step();
        chk("single_we_off", 32'(mem_we), 32'd0);
        chk("single_count",  32'(pixel_count), 32'd1);

        // Backpressure: 6 pixels while memory stalls
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe = 1'b1; row_index = 10'd0; column_index = 10'(10 + i); pixel = 12'(12'h100 + i);
            step();
        end
        strobe = 1'b0;
        chk("bp_ovf",  32'(overflow_err), 32'd1);
        chk("bp_we",   32'(mem_we), 32'd1);
        chk("bp_addr", 32'(mem_addr), 32'd10);
        step();
        chk("bp_hold_addr", 32'(mem_addr), 32'd10);
        chk("bp_hold_data", 32'(mem_data), 32'h100);
        chk("bp_hold_count", 32'(pixel_count), 32'd1);
        mem_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            chk("bp_drain_we",    32'(mem_we), 32'd1);
            chk("bp_drain_addr",  32'(mem_addr), 32'(10 + k));
            chk("bp_drain_data",  32'(mem_data), 32'(12'h100 + k));
            chk("bp_drain_count", 32'(pixel_count), 32'(1 + k));
        end
        step();
        chk("bp_end_we",    32'(mem_we), 32'd0);
        chk("bp_end_count", 32'(pixel_count), 32'd6);

        // Range errors
        strobe = 1'b1; row_index = 10'd480; column_index = 10'd0; pixel = 12'h111;
        step();
        strobe = 1'b0;
        chk("rng_row_err", 32'(range_err), 32'd1);
        step();
        chk("rng_row_we",    32'(mem_we), 32'd0);
        chk("rng_row_count", 32'(pixel_count), 32'd6);
        strobe = 1'b1; row_index = 10'd0; column_index = 10'd640;
        step();
        strobe = 1'b0;
        step();
        chk("rng_col_we",    32'(mem_we), 32'd0);
        step();
        chk("rng_col_count", 32'(pixel_count), 32'd6);

        // Reset mid-write: one entry held, three queued
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe = 1'b1; row_index = 10'd1; column_index = 10'(i); pixel = 12'(12'h200 + i);
            step();
        end
        strobe = 1'b0;
        chk("mid_we_before", 32'(mem_we), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_we",    32'(mem_we), 32'd0);
        chk("mid_addr",  32'(mem_addr), 32'd0);
        chk("mid_data",  32'(mem_data), 32'd0);
        chk("mid_count", 32'(pixel_count), 32'd0);
        chk("mid_ovf",   32'(overflow_err), 32'd0);
        chk("mid_rng",   32'(range_err), 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_quiet_we", 32'(mem_we), 32'd0);
        end

        // Frame completion on the 4x2 instance, all pixels 0xFFF
        for (int i = 0; i < 8; i++) begin
            b_strobe = 1'b1; b_row = 10'(i / 4); b_col = 10'(i % 4); b_pixel = 12'hFFF;
            step();
            chk("frm_no_early_done", 32'(b_done), 32'd0);
        end
        b_strobe = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            chk("frm_done_pulse", 32'(b_done), 32'(j == 2));
            if (j == 2) begin
                chk("frm_count_wrap", 32'(b_count), 32'd0);
                chk("frm_csum",       32'(b_csum), 32'(exp_csum));
            end
        end
        b_strobe = 1'b1; b_row = 10'd1; b_col = 10'd3; b_pixel = 12'h001;
        step();
        b_strobe = 1'b0;
        step();
        chk("frm9_addr", 32'(b_addr), 32'd7);
        step();
        chk("frm9_count", 32'(b_count), 32'd1);
        chk("frm9_done",  32'(b_done), 32'd0);
        chk("frm9_csum",  32'(b_csum), 32'(exp_csum));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pixel_receive_interface
`default_nettype wire
